// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller time-sharing a single full-adder cell
// IDLE -> RUN (WIDTH edges, LSB first) -> DONE (one-cycle result pulse)

module serial_add_fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int            CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_s;
   logic             fa_co;
   logic             accept;
   logic             last;

   serial_add_fa fa (
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   // start is only honoured outside RUN, so an in-flight addition is never disturbed
   assign accept = start && (state != RUN);
   assign last   = (state == RUN) && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nx = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == LAST) state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = start ? RUN : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh  <= '0;
         b_sh  <= '0;
         res   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else if (accept) begin
         a_sh  <= a;
         b_sh  <= b;
         carry <= cin;
         cnt   <= '0;
      end else if (state == RUN) begin
         a_sh  <= a_sh >> 1;
         b_sh  <= b_sh >> 1;
         carry <= fa_co;
         cnt   <= cnt + CW'(1);
         res   <= {fa_s, res[WIDTH-1:1]};
         // the final bit has not landed in res yet, so assemble it on the way into sum
         if (last) begin
            sum  <= {fa_s, res[WIDTH-1:1]};
            cout <= fa_co;
         end
      end
   end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed and random checks of serial_add_ctrl at WIDTH=8

module tb_serial_add_ctrl;
   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       cout;

   int         n_vec;
   int         n_err;
   logic [7:0] psum;
   logic       pcout;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] es;
      logic       ec;
   } vec_t;

   vec_t vecs [11];

   serial_add_ctrl #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [7:0] va, input logic [7:0] vb, input logic vc);
      a     = va;
      b     = vb;
      cin   = vc;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Call in the first cycle after the accepting edge; returns in the done cycle.
   task automatic expect_run(input string name, input logic [7:0] es, input logic ec, input int inj);
      bit ok_busy   = 1'b1;
      bit ok_hold   = 1'b1;
      bit ok_nodone = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         if (busy !== 1'b1) ok_busy = 1'b0;
         if (done !== 1'b0) ok_nodone = 1'b0;
         if ({cout, sum} !== {pcout, psum}) ok_hold = 1'b0;
         if (c == inj) begin
            a     = ~a;
            b     = 8'h5A;
            cin   = ~cin;
            start = 1'b1;
         end
         tick();
         if (c == inj) start = 1'b0;
      end
      check({name, " busy during run"}, 32'(ok_busy), 32'd1);
      check({name, " no early done"}, 32'(ok_nodone), 32'd1);
      check({name, " result held in run"}, 32'(ok_hold), 32'd1);
      check({name, " done pulse"}, 32'(done), 32'd1);
      check({name, " busy in done"}, 32'(busy), 32'd0);
      check({name, " sum"}, 32'(sum), 32'(es));
      check({name, " cout"}, 32'(cout), 32'(ec));
      psum  = es;
      pcout = ec;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst   = 1'b1;
      start = 1'b0;
      a     = 8'h00;
      b     = 8'h00;
      cin   = 1'b0;
      psum  = 8'h00;
      pcout = 1'b0;

      vecs[0]  = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
      vecs[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[3]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[4]  = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
      vecs[5]  = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
      vecs[6]  = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
      vecs[7]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
      vecs[8]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
      vecs[9]  = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
      vecs[10] = '{8'hC3, 8'h3C, 1'b0, 8'hFF, 1'b0};

      tick();
      tick();
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset sum", 32'(sum), 32'd0);
      check("reset cout", 32'(cout), 32'd0);
      rst = 1'b0;
      tick();
      check("idle busy", 32'(busy), 32'd0);

      for (int i = 0; i < 11; i++) begin
         launch(vecs[i].a, vecs[i].b, vecs[i].cin);
         expect_run($sformatf("vec%0d", i), vecs[i].es, vecs[i].ec, 0);
         tick();
         check($sformatf("vec%0d done drops", i), 32'(done), 32'd0);
      end

      // start and new operands during RUN cycle 3 must not disturb the addition
      launch(8'h21, 8'h13, 1'b0);
      expect_run("start in run", 8'h34, 1'b0, 3);
      tick();

      // reset at RUN cycle 4 aborts with no done pulse
      begin
         bit saw_done = 1'b0;
         launch(8'h33, 8'h44, 1'b1);
         tick();
         tick();
         tick();
         rst = 1'b1;
         tick();
         rst = 1'b0;
         check("abort busy", 32'(busy), 32'd0);
         check("abort done", 32'(done), 32'd0);
         check("abort sum", 32'(sum), 32'd0);
         check("abort cout", 32'(cout), 32'd0);
         for (int c = 0; c < 12; c++) begin
            if (done !== 1'b0) saw_done = 1'b1;
            tick();
         end
         check("abort no done", 32'(saw_done), 32'd0);
         psum  = 8'h00;
         pcout = 1'b0;
      end

      // start coinciding with reset is dropped
      a     = 8'h11;
      b     = 8'h22;
      start = 1'b1;
      rst   = 1'b1;
      tick();
      rst   = 1'b0;
      start = 1'b0;
      check("rst+start busy", 32'(busy), 32'd0);
      tick();
      check("rst+start still idle", 32'(busy), 32'd0);

      // back-to-back: start held in the done cycle re-enters RUN with no idle cycle
      launch(8'h01, 8'h02, 1'b0);
      expect_run("b2b first", 8'h03, 1'b0, 0);
      launch(8'h80, 8'h80, 1'b0);
      expect_run("b2b second", 8'h00, 1'b1, 0);

      for (int n = 0; n < 1000; n++) begin
         int         sp;
         logic [7:0] ra;
         logic [7:0] rb;
         logic       rc;
         logic [8:0] ref_val;
         sp = $urandom_range(0, 3);
         if (sp > 0) begin
            tick();
            check("rand done drops", 32'(done), 32'd0);
            for (int s = 1; s < sp; s++) tick();
         end
         ra      = 8'($urandom);
         rb      = 8'($urandom);
         rc      = 1'($urandom);
         ref_val = 9'(ra) + 9'(rb) + 9'(rc);
         launch(ra, rb, rc);
         expect_run($sformatf("rand%0d", n), ref_val[7:0], ref_val[8], 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
